// File: rtl/gpio_led_pkg.sv
// Shared types and constants for the GPIO-driven LED pattern generator.
package gpio_led_pkg;

    typedef enum logic [1:0] {
        LED_OFF     = 2'b00,
        LED_ON      = 2'b01,
        LED_BLINK   = 2'b10,
        LED_BREATHE = 2'b11
    } led_mode_t;

    localparam int BLINK_BASE     = 8;
    localparam int DEBOUNCE_TICKS = 4;

endpackage

// File: rtl/gpio_led_if.sv
// Bundles the GPIO command input and the LED/status outputs of the driver.
interface gpio_led_if #(
    parameter int LED_NUM = 4
) ();
    logic [3:0]         gpio_i;
    logic [LED_NUM-1:0] led_o;
    logic [1:0]         mode_o;
    logic               tick_o;

    modport master (output gpio_i, input led_o, mode_o, tick_o);
    modport slave  (input gpio_i, output led_o, mode_o, tick_o);
endinterface

// File: rtl/gpio_led_tick_gen.sv
// Timebase: strobes tick for one clk every TICK_DIV cycles.
module gpio_led_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (cnt == CNT_LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == CNT_LAST);
endmodule

// File: rtl/gpio_led_driver.sv
// Turns a 4-bit GPIO command into off/on/blink/breathe LED patterns, applied on tick boundaries.
// Define GPIO_LED_DEBOUNCE_EN to require a command to be stable for several ticks before acceptance.
module gpio_led_driver
    import gpio_led_pkg::*;
#(
    parameter int LED_NUM  = 4,
    parameter int TICK_DIV = 100000,
    parameter int PWM_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    gpio_led_if.slave   bus
);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    logic                tick;
    logic [3:0]          sync_p0, cmd_s;
    led_mode_t           state, next_state;
    logic [1:0]          speed, next_speed;
    logic [3:0]          applied;
    logic                accept;
    logic                phase;
    logic [5:0]          blink_cnt, blink_last;
    logic [2:0]          step_cnt, step_last;
    logic [PWM_BITS-1:0] duty, pwm_cnt;
    logic                dir_down;
    logic [LED_NUM-1:0]  led, led_next;

    function automatic logic [PWM_BITS:0] duty_step(input logic [PWM_BITS-1:0] d,
                                                     input logic down);
        logic [PWM_BITS:0] r;
        // Reversal happens on the step itself, so duty forms a triangle without dwelling at the ends.
        if (!down)
            r = (d == DUTY_MAX) ? {1'b1, d - 1'b1} : {1'b0, d + 1'b1};
        else
            r = (d == '0) ? {1'b0, d + 1'b1} : {1'b1, d - 1'b1};
        return r;
    endfunction

    gpio_led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            cmd_s   <= '0;
        end else begin
            sync_p0 <= bus.gpio_i;
            cmd_s   <= sync_p0;
        end
    end

    assign applied = {speed, state};

`ifdef GPIO_LED_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_TICKS);
    logic [3:0]      cand;
    logic [DB_W-1:0] db_cnt;

    assign accept = tick && (cmd_s != applied) && (cmd_s == cand) &&
                    (db_cnt == DB_W'(DEBOUNCE_TICKS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand   <= '0;
            db_cnt <= '0;
        end else if (tick) begin
            if (accept || cmd_s == applied) begin
                cand   <= cmd_s;
                db_cnt <= '0;
            end else if (cmd_s == cand) begin
                db_cnt <= db_cnt + 1'b1;
            end else begin
                cand   <= cmd_s;
                db_cnt <= DB_W'(1);
            end
        end
    end
`else
    assign accept = tick && (cmd_s != applied);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LED_OFF;
            speed <= '0;
        end else begin
            state <= next_state;
            speed <= next_speed;
        end
    end

    always_comb begin
        next_state = state;
        next_speed = speed;
        if (accept) begin
            next_state = led_mode_t'(cmd_s[1:0]);
            next_speed = cmd_s[3:2];
        end
    end

    always_comb begin
        led_next = '0;
        case (state)
            LED_OFF:     led_next = '0;
            LED_ON:      led_next = '1;
            LED_BLINK:   led_next = {LED_NUM{phase}};
            LED_BREATHE: led_next = {LED_NUM{pwm_cnt < duty}};
            default:     led_next = '0;
        endcase
    end

    always_comb begin
        blink_last = 6'((BLINK_BASE << speed) - 1);
        step_last  = 3'((1 << speed) - 1);
    end

    // Acceptance takes priority over stepping, so a new command always restarts cleanly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase     <= 1'b0;
            blink_cnt <= '0;
            duty      <= '0;
            dir_down  <= 1'b0;
            step_cnt  <= '0;
        end else if (accept) begin
            phase     <= 1'b1;
            blink_cnt <= '0;
            duty      <= '0;
            dir_down  <= 1'b0;
            step_cnt  <= '0;
        end else if (tick) begin
            if (state == LED_BLINK) begin
                if (blink_cnt == blink_last) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
            if (state == LED_BREATHE) begin
                if (step_cnt == step_last) begin
                    step_cnt         <= '0;
                    {dir_down, duty} <= duty_step(duty, dir_down);
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
            led     <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            led     <= led_next;
        end
    end

    assign bus.led_o  = led;
    assign bus.mode_o = state;
    assign bus.tick_o = tick;
endmodule
